// File: rtl/cic_comp_fir.sv
// 7-tap CIC droop-compensation FIR on decimated samples.
// One multiplier walks the taps one per clock, then rounds and saturates the sum.
module cic_comp_fir #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  localparam int PROD_W = DATA_WIDTH + 9;
  localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(64);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX  =
    ACC_WIDTH'((longint'(1) <<< (DATA_WIDTH - 1)) - longint'(1));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN  =
    ACC_WIDTH'(-(longint'(1) <<< (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

  state_t                       state, state_nxt;
  logic signed [DATA_WIDTH-1:0] dly [7];
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [2:0]                   idx;
  logic signed [DATA_WIDTH-1:0] x_sel;
  logic signed [PROD_W-1:0]     prod;

  function automatic logic signed [8:0] coef(input logic [2:0] k);
    case (k)
      3'd0, 3'd6: coef = -9'sd1;
      3'd1, 3'd5: coef =  9'sd4;
      3'd2, 3'd4: coef = -9'sd16;
      3'd3:       coef =  9'sd154;
      default:    coef =  9'sd0;
    endcase
  endfunction

  // Divide by 128 (coefficient gain) with round-half-up, then clamp to the output range.
  function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] r;
    r = (a + RND_HALF) >>> 7;
    if (r > SAT_MAX)      round_sat = DATA_WIDTH'(SAT_MAX);
    else if (r < SAT_MIN) round_sat = DATA_WIDTH'(SAT_MIN);
    else                  round_sat = DATA_WIDTH'(r);
  endfunction

  assign in_ready = (state == IDLE);

  always_comb begin
    x_sel = '0;
    for (int k = 0; k < 7; k++) begin
      if (idx == 3'(k)) x_sel = dly[k];
    end
  end

  assign prod = PROD_W'(x_sel) * PROD_W'(coef(idx));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MAC;
      MAC:     if (idx == 3'd6) state_nxt = ROUND;
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      for (int k = 0; k < 7; k++) dly[k] <= '0;
      acc       <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      case (state)
        // accept: newest sample enters tap 0
        IDLE: begin
          if (in_valid) begin
            for (int k = 6; k > 0; k--) dly[k] <= dly[k-1];
            dly[0] <= $signed(in_data);
            acc    <= '0;
            idx    <= '0;
          end
        end
        // multiply-accumulate, one tap per clock
        MAC: begin
          acc <= acc + ACC_WIDTH'(prod);
          idx <= idx + 3'd1;
        end
        // round, saturate, publish
        ROUND: begin
          out_data  <= round_sat(acc);
          out_valid <= 1'b1;
        end
        default: ;
      endcase
      // a strobe while busy outranks a simultaneous clear
      if (in_valid && (state != IDLE)) overrun <= 1'b1;
      else if (clr_overrun)            overrun <= 1'b0;
    end
  end

endmodule

// File: doc/cic_comp_fir.md
CIC_COMP_FIR -- requirements
Module: cic_comp_fir

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of signed two's-complement input and output samples.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, width of internal signed accumulator (>= DATA_WIDTH+9).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  one-cycle strobe marking a new decimated sample from the upstream CIC filter.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  signed input sample, sampled only when in_valid=1.
REQ-007 SHALL have port in_ready  output  1  high when the block is IDLE and will accept in_valid.
REQ-008 SHALL have port out_valid  output  1  one-cycle strobe marking a new out_data value.
REQ-009 SHALL have port out_data  output  DATA_WIDTH  signed compensated sample, held until the next out_valid.
REQ-010 SHALL have port overrun  output  1  sticky flag: an input strobe arrived while busy.
REQ-011 SHALL have port clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-012 SHALL implement a 7-tap FIR, fixed coefficients c0..c6 = -1, 4, -16, 154, -16, 4, -1 (sum 128), y = sum(ck * x[n-k]).
REQ-013 SHALL hold a 7-entry delay line; x[n] (newest) multiplies c0, x[n-6] multiplies c6.
REQ-014 SHALL use one multiplier, time-multiplexed: one tap product accumulated per clock.
REQ-015 SHALL use FSM states IDLE, MAC, ROUND.
REQ-016 IDLE: in_ready=1; on edge E0 with in_valid=1: shift in_data into delay line, clear accumulator, tap index=0, go to MAC.
REQ-017 MAC: edges E1..E7 each add c[idx]*x[n-idx] (full precision, sign-extended to ACC_WIDTH) and increment idx; after tap 6 (E7) go to ROUND.
REQ-018 ROUND: on E8, out_data = saturate((acc + 64) >>> 7) (arithmetic shift, round half up), out_valid=1 for exactly one cycle, go to IDLE.
REQ-019 Latency: out_valid SHALL be high in the cycle following E8, i.e. 8 clocks after the edge that sampled in_valid; minimum input spacing 9 clocks.
REQ-020 Saturation SHALL clamp to +(2^(DATA_WIDTH-1)-1) and -2^(DATA_WIDTH-1).
REQ-021 in_valid while state != IDLE SHALL be ignored (delay line and accumulator untouched) and SHALL set overrun.
REQ-022 clr_overrun and a simultaneous overrun event in the same cycle: set SHALL win (overrun stays 1).
REQ-023 in_valid arriving in the same cycle out_valid is high SHALL be accepted (state already IDLE).
REQ-024 out_data SHALL not change except on the ROUND edge.

Reset
REQ-025 reset=1 SHALL asynchronously force state=IDLE, delay line=0, accumulator=0, tap index=0, out_data=0, out_valid=0, overrun=0; in_ready=1 while reset is high.
REQ-026 reset asserted mid-MAC/ROUND SHALL abort the computation with no out_valid emitted; first sample after release starts from a zero delay line.

Verification
REQ-027 Impulse: in_data 1000 then six 0 samples (spacing 10 clk) -> out_data sequence -8, 31, -125, 1203, -125, 31, -8, then 0.
REQ-028 DC: constant 1000 for >= 7 samples -> out_data settles to 1000; constant -32768 -> -32768 (no saturation).
REQ-029 Saturation: alternating -32768, 32767, ... for 7 samples (last = -32768) -> out_data 32767.
REQ-030 Timing: in_valid at edge E0 -> in_ready low E0..E8, out_valid high exactly one cycle after E8; in_valid at E3 -> ignored, overrun=1, output unchanged from no-extra-sample case.
REQ-031 Overrun clear: overrun=1, clr_overrun=1 alone -> overrun 0 next cycle; clr_overrun with concurrent busy in_valid -> overrun stays 1.
REQ-032 Reset mid-MAC (at E4) -> no out_valid, out_data=0, next impulse of 1000 reproduces REQ-027 sequence.
